// File: rtl/cpr_symbol_scheduler.sv
// cpr_symbol_scheduler: sequences one frame command into per-symbol
// invocations of the cyclicPrefixRemoval core. It runs the
// ap_start/ap_ready/ap_done handshake and picks the CP length for each
// symbol from its position in the slot.
// Optional feature: define CPR_WATCHDOG_EN to add a per-symbol watchdog.
// When it fires, the scheduler enters WDOG_ERR and ends the frame with an error.
module cpr_symbol_scheduler #(
   parameter int SYM_W       = 8,
   parameter int CP_W        = 10,
   parameter int WDOG_CYCLES = 4096,
   parameter int WDOG_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [SYM_W-1:0]  cmd_num_sym,
   input  logic [SYM_W-1:0]  cmd_sym_per_slot,
   input  logic [CP_W-1:0]   cmd_cp_long,
   input  logic [CP_W-1:0]   cmd_cp_short,
   input  logic              abort,
   output logic              core_ap_start,
   input  logic              core_ap_ready,
   input  logic              core_ap_done,
   output logic [CP_W-1:0]   core_cp_len,
   output logic              busy,
   output logic [SYM_W-1:0]  sym_idx,
   output logic              frame_done,
   output logic              frame_err
);

   localparam logic [SYM_W-1:0] SYM_ONE  = SYM_W'(1);
   localparam logic [SYM_W-1:0] SYM_ZERO = {SYM_W{1'b0}};

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DONE = 3'd2,
      FINISH    = 3'd3
`ifdef CPR_WATCHDOG_EN
      , WDOG_ERR = 3'd4
`endif
   } state_t;

   state_t            state;
   logic [SYM_W-1:0]  num_sym_r;
   logic [SYM_W-1:0]  sym_per_slot_r;
   logic [CP_W-1:0]   cp_long_r;
   logic [CP_W-1:0]   cp_short_r;
   logic [SYM_W-1:0]  slot_pos;
   logic              abort_pend;

`ifdef CPR_WATCHDOG_EN
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
   logic [WDOG_W-1:0] wdog_cnt;
`endif

   logic              done_evt;
   logic              last_sym;
   logic              slot_wrap;
   logic              abort_now;
   logic [SYM_W-1:0]  next_slot_pos;
   logic [CP_W-1:0]   next_cp_len;

   // Decode the done event, the last-symbol condition and the next slot position / CP length
   always_comb begin
      done_evt      = 1'b0;
      last_sym      = (sym_idx == (num_sym_r - SYM_ONE));
      // A slot size of 0 or 1 wraps every symbol, so each symbol uses the long CP
      slot_wrap     = (sym_per_slot_r <= SYM_ONE) || (slot_pos == (sym_per_slot_r - SYM_ONE));
      abort_now     = abort_pend | abort;
      next_slot_pos = slot_wrap ? SYM_ZERO : (slot_pos + SYM_ONE);
      next_cp_len   = slot_wrap ? cp_long_r : cp_short_r;
      case (state)
         ISSUE:     done_evt = core_ap_ready & core_ap_done;
         WAIT_DONE: done_evt = core_ap_done;
         default:   done_evt = 1'b0;
      endcase
   end

   // Scheduler FSM with registered handshake, status and CP outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         num_sym_r      <= SYM_ZERO;
         sym_per_slot_r <= SYM_ZERO;
         cp_long_r      <= {CP_W{1'b0}};
         cp_short_r     <= {CP_W{1'b0}};
         slot_pos       <= SYM_ZERO;
         abort_pend     <= 1'b0;
         cmd_ready      <= 1'b0;
         core_ap_start  <= 1'b0;
         core_cp_len    <= {CP_W{1'b0}};
         busy           <= 1'b0;
         sym_idx        <= SYM_ZERO;
         frame_done     <= 1'b0;
         frame_err      <= 1'b0;
`ifdef CPR_WATCHDOG_EN
         wdog_cnt       <= {WDOG_W{1'b0}};
`endif
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               if (cmd_valid && cmd_ready) begin
                  num_sym_r      <= cmd_num_sym;
                  sym_per_slot_r <= cmd_sym_per_slot;
                  cp_long_r      <= cmd_cp_long;
                  cp_short_r     <= cmd_cp_short;
                  sym_idx        <= SYM_ZERO;
                  slot_pos       <= SYM_ZERO;
                  abort_pend     <= 1'b0;
                  cmd_ready      <= 1'b0;
                  busy           <= 1'b1;
                  if (cmd_num_sym == SYM_ZERO) begin
                     state      <= FINISH;
                     frame_done <= 1'b1;
                  end else begin
                     state         <= ISSUE;
                     core_ap_start <= 1'b1;
                     core_cp_len   <= cmd_cp_long;
`ifdef CPR_WATCHDOG_EN
                     wdog_cnt      <= {WDOG_W{1'b0}};
`endif
                  end
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE, WAIT_DONE: begin
               if (abort) begin
                  abort_pend <= 1'b1;
               end else begin
                  abort_pend <= abort_pend;
               end
`ifdef CPR_WATCHDOG_EN
               wdog_cnt <= wdog_cnt + WDOG_W'(1);
`endif
               if (done_evt) begin
                  if (last_sym || abort_now) begin
                     state         <= FINISH;
                     core_ap_start <= 1'b0;
                     frame_done    <= 1'b1;
                     frame_err     <= abort_now;
                  end else begin
                     state         <= ISSUE;
                     core_ap_start <= 1'b1;
                     sym_idx       <= sym_idx + SYM_ONE;
                     slot_pos      <= next_slot_pos;
                     core_cp_len   <= next_cp_len;
`ifdef CPR_WATCHDOG_EN
                     wdog_cnt      <= {WDOG_W{1'b0}};
`endif
                  end
               end else if ((state == ISSUE) && core_ap_ready) begin
                  state         <= WAIT_DONE;
                  core_ap_start <= 1'b0;
               end
`ifdef CPR_WATCHDOG_EN
               else if (wdog_cnt == WDOG_LAST) begin
                  state         <= WDOG_ERR;
                  core_ap_start <= 1'b0;
                  frame_done    <= 1'b1;
                  frame_err     <= 1'b1;
               end
`endif
               else begin
                  state <= state;
               end
            end
            FINISH: begin
               state      <= IDLE;
               abort_pend <= 1'b0;
               cmd_ready  <= 1'b1;
               busy       <= 1'b0;
            end
`ifdef CPR_WATCHDOG_EN
            WDOG_ERR: begin
               state      <= IDLE;
               abort_pend <= 1'b0;
               cmd_ready  <= 1'b1;
               busy       <= 1'b0;
            end
`endif
            default: begin
               state         <= IDLE;
               core_ap_start <= 1'b0;
               cmd_ready     <= 1'b0;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule
